img_mem_writer: RTL and testbench
=================================

# img_mem_writer

Stream-to-frame-buffer writer for the VGA image path: accepts one RGB888 pixel per handshake from a file/UART pixel source and writes it into the dual-port image memory that the VGA-side memory reader scans out. Generates the linear write address (row-major, H_SIZE pixels per row) with a choice of top-down or BMP-style bottom-up row order and optional BGR→RGB byte swap. Runs one frame per `start` pulse and reports completion.

## Interface
- `H_SIZE`, 640, pixels per row
- `V_SIZE`, 480, rows per frame
- `BOTTOM_UP`, 1, 1: first received row is written to row V_SIZE-1 (BMP order); 0: first row goes to row 0
- `SWAP_BGR`, 1, 1: input is {B,G,R}, stored as {R,G,B}; 0: stored unchanged
- `AW`, $clog2(H_SIZE*V_SIZE), address width (derived, not overridden)

One clock; reset is asynchronous and active-low.
- `clk`  in  1  system/pixel clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  single-cycle pulse; arms a frame write when idle
- `s_valid`  in  1  source pixel valid
- `s_data`  in  24  source pixel, byte order per SWAP_BGR
- `s_ready`  out  1  writer accepts a pixel this cycle
- `we`  out  1  memory write enable (registered)
- `addr`  out  AW  memory write address (registered)
- `wdata`  out  24  memory write data, {R,G,B} (registered)
- `busy`  out  1  high from frame arm until frame_done cycle inclusive
- `frame_done`  out  1  one-cycle pulse, coincides with the last pixel's write

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: `s_ready`=0, `busy`=0. `start`=1 → WRITE; clear column counter `x`=0, row counter `y`=0; row base `base` = BOTTOM_UP ? (V_SIZE-1)*H_SIZE : 0.
- WRITE: `s_ready`=1, `busy`=1. Transfer = `s_valid` & `s_ready`. Per transfer: register `we`=1, `addr`=`base`+`x`, `wdata`=SWAP_BGR ? {s_data[7:0],s_data[15:8],s_data[23:16]} : s_data.
- Counters per transfer: `x`<H_SIZE-1 → `x`+1; `x`=H_SIZE-1 → `x`=0, `y`+1, `base` -= H_SIZE (BOTTOM_UP) or += H_SIZE. No multiplier; `base` updates by add/subtract only.
- Transfer with `x`=H_SIZE-1 and `y`=V_SIZE-1 → DONE (counters not advanced past frame end).
- DONE (exactly one cycle): `frame_done`=1, `busy`=1, `s_ready`=0 → IDLE.
- No transfer in a cycle → `we`=0 next cycle; `addr`/`wdata` hold last values.
- `start` outside IDLE ignored. `s_valid` outside WRITE ignored (not consumed).
- Address width: `base`+`x` computed at AW bits; max value H_SIZE*V_SIZE-1, never wraps.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release): state IDLE, `x`=`y`=0, `base`=0, `s_ready`=0, `we`=0, `addr`=0, `wdata`=0, `busy`=0, `frame_done`=0.
- Reset mid-frame: frame abandoned immediately, no `frame_done`, writes already issued stand; next `start` restarts from first row.
- `start` sampled at edge N → `s_ready`=1 after edge N; first transfer possible at edge N+1.
- Transfer at edge M → `we`/`addr`/`wdata` valid during cycle after edge M (latency 1), independent of back-to-back transfers; throughput 1 pixel/clk.
- Last transfer at edge L → after edge L: `we`=1 (last address), `frame_done`=1, `s_ready`=0; after edge L+1: IDLE, `we`=0, `busy`=0.
- `start` at edge L+1 (while in DONE) ignored; earliest re-arm is the cycle after DONE.
- Row wrap and frame end occur on the same transfer edge as the x=H_SIZE-1 write; no bubble.

## Test plan
- H_SIZE=4, V_SIZE=2, BOTTOM_UP=0, SWAP_BGR=0; start, 8 back-to-back pixels 0x000001..0x000008 → addr 0..7 on consecutive cycles, wdata matches, frame_done with addr 7, s_ready low after.
- Same size, BOTTOM_UP=1: 8 pixels → addr sequence 4,5,6,7,0,1,2,3; frame_done with addr 3.
- SWAP_BGR=1: s_data=0x112233 → wdata=0x332211.
- Random s_valid gaps (~50% duty): we asserted only cycle after each transfer, no skipped/duplicated addresses, 8 writes total.
- rst_n low after 3 pixels, then start again: no frame_done from aborted frame; new frame begins at base (0 or 4) with x=0.
- start pulses during WRITE and DONE, s_valid in IDLE → ignored: no counter change, no writes, single frame_done per armed frame.

Source files
------------

// File: rtl/img_mem_writer.sv
// ---------------------------------------------------------------------------
// img_mem_writer : RGB888 stream to row-major frame buffer writer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module img_mem_writer #(
  parameter int H_SIZE    = 640,
  parameter int V_SIZE    = 480,
  parameter bit BOTTOM_UP = 1'b1,
  parameter bit SWAP_BGR  = 1'b1,
  localparam int AW       = $clog2(H_SIZE*V_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          s_valid,
  input  logic [23:0]   s_data,
  output logic          s_ready,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic [23:0]   wdata,
  output logic          busy,
  output logic          frame_done
);

  localparam int XW = (H_SIZE > 1) ? $clog2(H_SIZE) : 1;
  localparam int YW = (V_SIZE > 1) ? $clog2(V_SIZE) : 1;

  localparam logic [AW-1:0] C_ROW_STEP  = AW'(H_SIZE);
  localparam logic [AW-1:0] C_LAST_BASE = AW'((V_SIZE-1)*H_SIZE);
  localparam logic [XW-1:0] C_X_LAST    = XW'(H_SIZE-1);
  localparam logic [YW-1:0] C_Y_LAST    = YW'(V_SIZE-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [AW-1:0]   base_q, base_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [23:0]     wdata_q, wdata_d;
  logic [23:0]     pix_rgb;

  assign pix_rgb = SWAP_BGR ? {s_data[7:0], s_data[15:8], s_data[23:16]} : s_data;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    base_d     = base_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    s_ready    = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITE;
          x_d     = '0;
          y_d     = '0;
          base_d  = BOTTOM_UP ? C_LAST_BASE : '0;
        end
      end
      S_WRITE: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          we_d    = 1'b1;
          addr_d  = base_q + AW'(x_q);
          wdata_d = pix_rgb;
          // Row base walks by one row per wrap so no multiplier is needed.
          if (x_q == C_X_LAST) begin
            if (y_q == C_Y_LAST) begin
              state_d = S_DONE;
            end else begin
              x_d    = '0;
              y_d    = y_q + 1'b1;
              base_d = BOTTOM_UP ? (base_q - C_ROW_STEP) : (base_q + C_ROW_STEP);
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we    = we_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_img_mem_writer.sv
// ---------------------------------------------------------------------------
// tb_img_mem_writer : randomized bench for two img_mem_writer configurations
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_img_mem_writer;

  localparam int H   = 4;
  localparam int V   = 2;
  localparam int TAW = $clog2(H*V);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            s_valid;
  logic [23:0]     s_data;

  logic            s_ready0, we0, busy0, fd0;
  logic [TAW-1:0]  addr0;
  logic [23:0]     wdata0;
  logic            s_ready1, we1, busy1, fd1;
  logic [TAW-1:0]  addr1;
  logic [23:0]     wdata1;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Top-down, no swap
  img_mem_writer #(.H_SIZE(H), .V_SIZE(V), .BOTTOM_UP(1'b0), .SWAP_BGR(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready0), .we(we0), .addr(addr0), .wdata(wdata0),
    .busy(busy0), .frame_done(fd0)
  );

  // Bottom-up, BGR swap
  img_mem_writer #(.H_SIZE(H), .V_SIZE(V), .BOTTOM_UP(1'b1), .SWAP_BGR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready1), .we(we1), .addr(addr1), .wdata(wdata1),
    .busy(busy1), .frame_done(fd1)
  );

  // Reference model: frame progress is tracked as a pixel index only.
  int          m_phase;   // 0 idle, 1 accepting pixels, 2 completion cycle
  int          m_n;
  logic        m_we;
  logic [31:0] m_addr0, m_addr1;
  logic [23:0] m_wdata0, m_wdata1;

  function automatic int addr_of(input int k, input bit bottom_up);
    int row, col;
    row = k / H;
    col = k % H;
    return (bottom_up ? (V - 1 - row) : row) * H + col;
  endfunction

  function automatic logic [23:0] bgr_to_rgb(input logic [23:0] d);
    logic [7:0] b, g, r;
    b = d[23:16];
    g = d[15:8];
    r = d[7:0];
    return {r, g, b};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  <= 0;
      m_n      <= 0;
      m_we     <= 1'b0;
      m_addr0  <= '0;
      m_addr1  <= '0;
      m_wdata0 <= '0;
      m_wdata1 <= '0;
    end else begin
      m_we <= 1'b0;
      if (m_phase == 0) begin
        if (start) begin
          m_phase <= 1;
          m_n     <= 0;
        end
      end else if (m_phase == 1) begin
        if (s_valid) begin
          m_we     <= 1'b1;
          m_addr0  <= 32'(addr_of(m_n, 1'b0));
          m_addr1  <= 32'(addr_of(m_n, 1'b1));
          m_wdata0 <= s_data;
          m_wdata1 <= bgr_to_rgb(s_data);
          m_n      <= m_n + 1;
          if (m_n == H*V - 1) m_phase <= 2;
        end
      end else begin
        m_phase <= 0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_val("s_ready0", 32'(s_ready0), 32'(m_phase == 1));
    check_val("s_ready1", 32'(s_ready1), 32'(m_phase == 1));
    check_val("busy0",    32'(busy0),    32'(m_phase != 0));
    check_val("busy1",    32'(busy1),    32'(m_phase != 0));
    check_val("fd0",      32'(fd0),      32'(m_phase == 2));
    check_val("fd1",      32'(fd1),      32'(m_phase == 2));
    check_val("we0",      32'(we0),      32'(m_we));
    check_val("we1",      32'(we1),      32'(m_we));
    check_val("addr0",    32'(addr0),    m_addr0);
    check_val("addr1",    32'(addr1),    m_addr1);
    check_val("wdata0",   32'(wdata0),   32'(m_wdata0));
    check_val("wdata1",   32'(wdata1),   32'(m_wdata1));
  endtask

  // Inputs change on the falling edge; outputs are checked one full cycle later.
  task automatic drive(input bit st, input bit v, input logic [23:0] d);
    start   = st;
    s_valid = v;
    s_data  = d;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int cyc;
    rst_n   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    @(negedge clk);
    drive(1'b1, 1'b1, 24'hABCDEF);
    check_val("rst_we",   32'(we0),   32'd0);
    check_val("rst_busy", 32'(busy1), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0);

    // Back-to-back frame with pixels 1..8
    drive(1'b1, 1'b0, '0);
    for (int i = 1; i <= H*V; i++) drive(1'b0, 1'b1, 24'(i));
    check_val("last_addr0", 32'(addr0),  32'd7);
    check_val("last_addr1", 32'(addr1),  32'd3);
    check_val("last_fd",    32'(fd0),    32'd1);
    check_val("last_wd0",   32'(wdata0), 32'h000008);
    drive(1'b1, 1'b1, 24'h555555);  // start while in completion cycle is ignored
    check_val("post_busy",  32'(busy0),  32'd0);
    drive(1'b0, 1'b1, 24'h666666);  // valid while idle is ignored
    check_val("idle_we",    32'(we0),    32'd0);

    // Byte-order frame
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 24'h112233);
    check_val("swap1", 32'(wdata1), 32'h332211);
    check_val("swap0", 32'(wdata0), 32'h112233);
    for (int i = 1; i < H*V; i++) drive(1'b0, 1'b1, 24'($urandom));
    drive(1'b0, 1'b0, '0);

    // Random gaps, stray start pulses, stray valid in idle
    for (int f = 0; f < 8; f++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 24'($urandom));
      cyc = 0;
      while (m_phase != 0 && cyc < 200) begin
        drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 24'($urandom));
        cyc++;
      end
      check_val("frame_bound", 32'(m_phase), 32'd0);
      for (int k = 0; k < 3; k++) drive(1'b0, 1'($urandom_range(0, 1)), 24'($urandom));
    end

    // Reset mid-frame, then a clean frame
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 24'($urandom));
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 24'h777777);
    check_val("abort_fd", 32'(fd0), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 24'h010203);
    check_val("restart_addr0", 32'(addr0), 32'd0);
    check_val("restart_addr1", 32'(addr1), 32'd4);
    for (int i = 1; i < H*V; i++) drive(1'b0, 1'($urandom_range(0, 1)) | (i == H*V-1), 24'($urandom));
    cyc = 0;
    while (m_phase != 0 && cyc < 100) begin
      drive(1'b0, 1'b1, 24'($urandom));
      cyc++;
    end
    check_val("restart_bound", 32'(m_phase), 32'd0);
    drive(1'b0, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
